// File: rtl/act_quant_pkg.sv
// act_quant_pkg
// Shared definitions for the requantise-and-activate pipeline:
//   act_mode_e   activation mode encodings (2'b11 behaves as plain ReLU)
//   DEF_*        default lane count and widths used by act_quant_pipe / act_lane
//   SAT_CNT_W    width of the saturation beat counter
//   sat_inc()    sticky increment of the saturation counter
package act_quant_pkg;

  typedef enum logic [1:0] {
    ACT_RELU     = 2'b00,
    ACT_RELU_CAP = 2'b01,
    ACT_SSAT     = 2'b10,
    ACT_RELU_ALT = 2'b11
  } act_mode_e;

  localparam int DEF_LANES   = 4;
  localparam int DEF_IN_W    = 32;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_SHIFT_W = 5;
  localparam int SAT_CNT_W   = 16;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane
// Per-lane datapath, split into two independent combinational halves so the
// parent can put a register stage between them.
//   Shift half (stage 1):  x_i, shift_i -> s_o (IN_W+1 bit arithmetic shift), neg_o
//   Clamp half (stage 2):  s_i, neg_i, mode_i, cap_i -> y_o, sat_o
// Build option: ACT_ROUND_EN adds round-half-up ahead of the shift; when
// undefined the shift truncates and the rounding adder is not built.
module act_lane
  import act_quant_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic [IN_W-1:0]    x_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [IN_W:0]      s_o,
  output logic               neg_o,
  input  logic [IN_W:0]      s_i,
  input  logic               neg_i,
  input  logic [1:0]         mode_i,
  input  logic [OUT_W-1:0]   cap_i,
  output logic [OUT_W-1:0]   y_o,
  output logic               sat_o
);

  localparam int EXT_W = IN_W + 1;

  logic signed [EXT_W-1:0] x_ext;

  assign x_ext = {x_i[IN_W-1], x_i};
  // Zeroing keys off the pre-shift sign, so a small negative that rounds to 0
  // still reads as negative.
  assign neg_o = x_i[IN_W-1];

`ifdef ACT_ROUND_EN
  logic signed [EXT_W-1:0] bias;
  logic signed [EXT_W-1:0] x_rnd;

  always_comb begin
    bias = '0;
    if (shift_i != '0) begin
      bias = EXT_W'(1) << (shift_i - SHIFT_W'(1));
    end
  end

  // One extra bit of headroom means the bias add can never wrap.
  assign x_rnd = x_ext + bias;
  assign s_o   = x_rnd >>> shift_i;
`else
  assign s_o = x_ext >>> shift_i;
`endif

  logic signed [EXT_W-1:0] s_val;
  logic signed [EXT_W-1:0] cap_ext;
  logic signed [EXT_W-1:0] umax;
  logic signed [EXT_W-1:0] smax;
  logic signed [EXT_W-1:0] smin;

  assign s_val   = s_i;
  assign cap_ext = {{(EXT_W-OUT_W){1'b0}}, cap_i};
  assign umax    = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  assign smax    = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign smin    = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // sat_o flags only clamp events; negative zeroing is not a saturation.
  always_comb begin
    y_o   = s_i[OUT_W-1:0];
    sat_o = 1'b0;
    case (act_mode_e'(mode_i))
      ACT_SSAT: begin
        if (s_val > smax) begin
          y_o   = smax[OUT_W-1:0];
          sat_o = 1'b1;
        end else if (s_val < smin) begin
          y_o   = smin[OUT_W-1:0];
          sat_o = 1'b1;
        end
      end
      ACT_RELU_CAP: begin
        if (neg_i) begin
          y_o = '0;
        end else if (s_val > cap_ext) begin
          y_o   = cap_i;
          sat_o = 1'b1;
        end
      end
      default: begin
        if (neg_i) begin
          y_o = '0;
        end else if (s_val > umax) begin
          y_o   = {OUT_W{1'b1}};
          sat_o = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/act_quant_pipe.sv
// act_quant_pipe
// Two-stage streaming requantise + activation for LANES accumulator lanes.
//   clk, rst_n                 clock, async active-low reset
//   cfg_shift/cfg_mode/cfg_cap per-beat configuration, captured with the beat
//   in_valid/in_ready/in_data  input stream (lane i at [i*IN_W +: IN_W])
//   out_valid/out_ready/out_data output stream (lane i at [i*OUT_W +: OUT_W])
//   sat_cnt, cnt_clr           sticky count of beats with a clamped lane, sync clear
// Stage 1 holds the shifted (optionally rounded) lanes, stage 2 the clamped
// result. in_ready is combinational from out_ready through the stage enables.
// Build option: ACT_ROUND_EN (see act_lane) selects rounding before the shift.
module act_quant_pipe
  import act_quant_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic [1:0]             cfg_mode,
  input  logic [OUT_W-1:0]       cfg_cap,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [SAT_CNT_W-1:0]   sat_cnt,
  input  logic                   cnt_clr
);

  localparam int EXT_W = IN_W + 1;

  logic                    s1_en;
  logic                    s2_en;
  logic                    in_acc;

  logic                    s1_v_q;
  logic [LANES*EXT_W-1:0]  s1_s_q;
  logic [LANES*EXT_W-1:0]  s1_s_d;
  logic [LANES-1:0]        s1_neg_q;
  logic [LANES-1:0]        s1_neg_d;
  logic [1:0]              s1_mode_q;
  logic [OUT_W-1:0]        s1_cap_q;

  logic                    s2_v_q;
  logic [LANES*OUT_W-1:0]  s2_y_q;
  logic [LANES*OUT_W-1:0]  s2_y_d;
  logic                    s2_sat_q;
  logic [LANES-1:0]        lane_sat;

  logic [SAT_CNT_W-1:0]    sat_cnt_q;
  logic [SAT_CNT_W-1:0]    sat_cnt_d;

  assign s2_en    = ~s2_v_q | out_ready;
  assign s1_en    = ~s1_v_q | s2_en;
  // Gating with rst_n keeps the source from seeing ready during reset.
  assign in_ready = rst_n & s1_en;
  assign in_acc   = in_valid & in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .x_i    (in_data[i*IN_W +: IN_W]),
      .shift_i(cfg_shift),
      .s_o    (s1_s_d[i*EXT_W +: EXT_W]),
      .neg_o  (s1_neg_d[i]),
      .s_i    (s1_s_q[i*EXT_W +: EXT_W]),
      .neg_i  (s1_neg_q[i]),
      .mode_i (s1_mode_q),
      .cap_i  (s1_cap_q),
      .y_o    (s2_y_d[i*OUT_W +: OUT_W]),
      .sat_o  (lane_sat[i])
    );
  end

  // Mode and cap ride along in stage 1 so later cfg changes never touch
  // a beat that was already accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_s_q    <= '0;
      s1_neg_q  <= '0;
      s1_mode_q <= '0;
      s1_cap_q  <= '0;
    end else begin
      if (s1_en) begin
        s1_v_q <= in_acc;
      end
      if (in_acc) begin
        s1_s_q    <= s1_s_d;
        s1_neg_q  <= s1_neg_d;
        s1_mode_q <= cfg_mode;
        s1_cap_q  <= cfg_cap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q   <= 1'b0;
      s2_y_q   <= '0;
      s2_sat_q <= 1'b0;
    end else if (s2_en) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_y_q   <= s2_y_d;
        s2_sat_q <= |lane_sat;
      end
    end
  end

  // Counted when the beat leaves stage 2; clear takes priority.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr) begin
      sat_cnt_d = '0;
    end else if (s2_v_q && out_ready && s2_sat_q) begin
      sat_cnt_d = sat_inc(sat_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_y_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: doc/act_quant_pipe.md
# act_quant_pipe

Multi-lane, pipelined requantise-and-activate stage placed between the 32-bit accumulator bank and the activation writeback buffer. It takes LANES signed accumulator values per beat, right-shifts them by a programmable amount, applies the selected activation and saturation, and emits OUT_W-bit results. It is the streaming, parametrised successor to the single-lane combinational ReLU, adding valid/ready flow control, modes and a saturation counter.

## Interface
- LANES, 4, lanes per beat
- IN_W, 32, signed accumulator width per lane
- OUT_W, 8, output width per lane
- SHIFT_W, 5, shift field width; shift range 0..2^SHIFT_W-1, must be < IN_W
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_shift  in  SHIFT_W  right-shift amount, sampled with each accepted beat
- cfg_mode  in  2  00 ReLU, 01 ReLU-cap, 10 signed saturate, 11 treated as 00; sampled per beat
- cfg_cap  in  OUT_W  unsigned ceiling for ReLU-cap, sampled per beat
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W], two's complement
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]
- sat_cnt  out  16  beats with at least one saturated/clamped lane
- cnt_clr  in  1  synchronous clear of sat_cnt

## Operation
- Per lane, per beat: s = x >>> cfg_shift (arithmetic), computed in IN_W+1 bits.
- ReLU: x<0 -> 0; s > 2^OUT_W-1 -> all ones; else s[OUT_W-1:0].
- ReLU-cap: x<0 -> 0; s > cfg_cap -> cfg_cap; else s.
- Signed saturate: clamp s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Negative zeroing uses the sign of the pre-shift input x.
- A lane "saturates" when the clamp, not the zeroing, alters the value. sat_cnt increments by 1 per beat leaving stage 2 with any saturated lane; sticks at 0xFFFF; cnt_clr wins over a simultaneous increment.
- Config travels with the beat; changing cfg_* mid-stream affects only later-accepted beats.

## Timing
- Two register stages: S1 = shift (+round), S2 = activation/clamp. Latency 2 cycles from acceptance to out_valid with out_ready held high; throughput 1 beat/cycle.
- Stage enables: s2_en = ~s2_v | out_ready; s1_en = ~s1_v | s2_en; in_ready = s1_en (combinational from out_ready; documented path).
- out_data/out_valid hold stable while out_valid & ~out_ready.
- No beat dropped, duplicated or reordered under any backpressure pattern; max 2 beats in flight.
- Reset: out_valid 0, out_data 0, sat_cnt 0, all stage valids 0; in_ready forced 0 while rst_n low, 1 on first cycle after release. Reset mid-stream discards in-flight beats.

## Configuration
- ACT_ROUND_EN defined: round-half-up before shift, s = (x + 2^(cfg_shift-1)) >>> cfg_shift for cfg_shift>0 (add in IN_W+1 bits, no wrap); cfg_shift=0 unchanged.
- Undefined: pure truncating arithmetic shift; rounding adder absent.

## Structure
- Package act_quant_pkg: mode encodings (ACT_RELU, ACT_RELU_CAP, ACT_SSAT), default widths, sat_cnt width.
- One sub-module act_lane: per-lane shift/round and clamp logic with saturate flag; instantiated LANES times, top holds stage registers, handshake and sat_cnt.

## Test plan
- ReLU, shift 0, lanes {-5, 100, 300, 0} -> out {0x00, 0x64, 0xFF, 0x00} two cycles later; sat_cnt = 1.
- ReLU, shift 4, lane 24 -> 0x01 without ACT_ROUND_EN, 0x02 with; lane -24 -> 0x00 both builds.
- ReLU-cap, cap 6, shift 0, lanes {10, 3, -1, 6} -> {0x06, 0x03, 0x00, 0x06}; sat_cnt +1.
- Signed saturate, shift 0, lanes {-200, 200, -3, 127} -> {0x80, 0x7F, 0xFD, 0x7F}.
- Stream 6 beats, out_ready low 5 cycles mid-stream: in_ready drops once 2 beats held, out_data stable, all 6 emerge in order exactly once.
- Reset with 2 beats in flight: out_valid 0 immediately, sat_cnt 0; after release no stale beat appears; cnt_clr with simultaneous saturation leaves sat_cnt 0.
